// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the RV32I integer register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   rf_state_e           : sweep FSM states (clear sweep, normal operation)
package regfile_mp_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard for the register file.
// One bit per register marks "issued, not yet written back"; the x0 bit is never set.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all pending bits)
//   run              block is out of the clear sweep; busy lookups are forced to 0 otherwise
//   set_en, set_idx  issue of an instruction with destination set_idx
//   clr_en, clr_idx  writeback to clr_idx
//   ra               packed read addresses, port i at [i*AW +: AW]
//   busy             per-port busy flag
module regfile_mp_sb_scoreboard #(
    parameter int NREGS   = 32,
    parameter int NR_READ = 2,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_idx,
    input  logic                  clr_en,
    input  logic [AW-1:0]         clr_idx,
    input  logic [NR_READ*AW-1:0] ra,
    output logic [NR_READ-1:0]    busy
);

    logic [NREGS-1:0] pending;

    // Set is applied after clear so a same-cycle issue to the register being
    // written back keeps it pending: the newly issued producer is still outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_en && clr_idx != '0) begin
                pending[clr_idx] <= 1'b0;
            end
            if (set_en && set_idx != '0) begin
                pending[set_idx] <= 1'b1;
            end
        end
    end

    // A consumer reading the register being written back this cycle takes the
    // forwarded data, so it is not busy unless a new producer is issued to it.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NR_READ; i++) begin
            busy[i] = run
                   && ra[i*AW +: AW] != '0
                   && pending[ra[i*AW +: AW]]
                   && !(BYPASS != 0
                        && clr_en && clr_idx == ra[i*AW +: AW]
                        && !(set_en && set_idx == ra[i*AW +: AW]));
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// RV32I integer register file: NR_READ combinational read ports, one write port,
// x0 hardwired to zero, optional write-to-read bypass, hardware clear sweep after
// reset and a pending-write scoreboard feeding issue hazard logic.
// Ports:
//   clk, rst             clock, synchronous active-high reset (restarts the sweep)
//   ra / rd / rd_busy    per-port read address, data and pending-write flag
//   we, wa, wd           writeback port
//   iss_valid, iss_rd    issued instruction and its destination register
//   init_done            sweep finished; writes and issues are accepted
//
// State table:
//   RF_CLEAR | sweeping zeros into x1..x(NREGS-1); we/iss ignored, reads return 0
//   RF_RUN   | normal operation until the next reset
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NR_READ = 2,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR_READ*AW-1:0]   ra,
    output logic [NR_READ*XLEN-1:0] rd,
    output logic [NR_READ-1:0]      rd_busy,
    input  logic                    we,
    input  logic [AW-1:0]           wa,
    input  logic [XLEN-1:0]         wd,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rd,
    output logic                    init_done
);

    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clr_wr;
    logic            run;
    logic [XLEN-1:0] regs [NREGS];

    assign run = (state_q == RF_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            cnt_q     <= AW'(1);
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_done <= run;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_wr  = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_wr = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RF_RUN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    // Storage has no reset of its own; the sweep is what zeroes it. Entry 0 is
    // never written and never observed because reads of x0 are forced to 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_wr) begin
                regs[cnt_q] <= '0;
            end else if (run && we && wa != '0) begin
                regs[wa] <= wd;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NR_READ; i++) begin
            if (run && ra[i*AW +: AW] != '0) begin
                if (BYPASS != 0 && we && wa == ra[i*AW +: AW]) begin
                    rd[i*XLEN +: XLEN] = wd;
                end else begin
                    rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
                end
            end
        end
    end

    regfile_mp_sb_scoreboard #(
        .NREGS   (NREGS),
        .NR_READ (NR_READ),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .set_en  (run && iss_valid),
        .set_idx (iss_rd),
        .clr_en  (run && we),
        .clr_idx (wa),
        .ra      (ra),
        .busy    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NR    = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR*AW-1:0]     ra;
    logic [NR*XLEN-1:0]   rd;
    logic [NR-1:0]        rd_busy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 init_done;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents and outstanding producers.
    logic [XLEN-1:0] mem_m [NREGS];
    bit              pend_m [NREGS];
    bit              run_m;

    always #5 clk = ~clk;

    regfile_mp_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int p);
        return ra[p*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int p);
        logic [AW-1:0] a = port_addr(p);
        if (!run_m || a == 0) return '0;
        if (we && wa == a) return wd;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input int p);
        logic [AW-1:0] a = port_addr(p);
        if (!run_m || a == 0) return 1'b0;
        return pend_m[a] && !(we && wa == a && !(iss_valid && iss_rd == a));
    endfunction

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle_inputs();
        we = 0; wa = 0; wd = 0; iss_valid = 0; iss_rd = 0;
    endtask

    // Check combinational outputs mid-cycle, then apply one clock edge to DUT and model.
    task automatic cycle(input string tag);
        @(negedge clk);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s_rd%0d", tag, p), rd[p*XLEN +: XLEN], exp_rd(p));
            chk($sformatf("%s_busy%0d", tag, p), {31'b0, rd_busy[p]}, {31'b0, exp_busy(p)});
        end
        @(posedge clk);
        if (run_m) begin
            if (we && wa != 0) begin
                mem_m[wa]  = wd;
                pend_m[wa] = 0;
            end
            if (iss_valid && iss_rd != 0) pend_m[iss_rd] = 1;
        end
        #1;
    endtask

    task automatic model_reset();
        run_m = 0;
        for (int r = 0; r < NREGS; r++) begin
            mem_m[r]  = '0;
            pend_m[r] = 0;
        end
    endtask

    // Release reset and poll for init_done; early sweep cycles carry junk
    // writes/issues that must be ignored.
    task automatic wait_init(input string tag);
        int n = 0;
        rst = 0;
        while (!init_done && n < 100) begin
            if (n < 20) begin
                we = 1'($urandom); wa = AW'($urandom); wd = $urandom;
                iss_valid = 1'($urandom); iss_rd = AW'($urandom);
            end else begin
                idle_inputs();
            end
            set_ra($urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1));
            cycle({tag, "_clear"});
            n++;
        end
        chk({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
        chk({tag, "_init_lat"}, {31'b0, (n >= NREGS-1 && n <= NREGS)}, 32'd1);
        idle_inputs();
        run_m = 1;
    endtask

    initial begin
        model_reset();
        rst = 1;
        idle_inputs();
        set_ra(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_busy", {30'b0, rd_busy}, 32'd0);
        wait_init("t1");

        for (int a = 1; a < NREGS; a++) begin
            set_ra(a, NREGS - a);
            cycle("t1_sweep");
        end

        // write with same-cycle read, then stored read
        we = 1; wa = 5; wd = 32'hDEADBEEF; set_ra(5, 0);
        cycle("t2_byp");
        idle_inputs();
        cycle("t2_stored");
        chk("t2_x5", rd[XLEN-1:0], 32'hDEADBEEF);

        // x0 write and issue are discarded
        we = 1; wa = 0; wd = 32'h1234; iss_valid = 1; iss_rd = 0; set_ra(0, 0);
        cycle("t3_x0w");
        idle_inputs();
        cycle("t3_x0r");

        // issue x7, busy, writeback bypass clears busy
        iss_valid = 1; iss_rd = 7; set_ra(0, 0);
        cycle("t4_iss");
        idle_inputs(); set_ra(0, 7);
        cycle("t4_busy");
        we = 1; wa = 7; wd = 32'h55;
        cycle("t4_wb");
        idle_inputs();
        cycle("t4_after");
        chk("t4_rd1", rd[XLEN +: XLEN], 32'h55);

        // same-cycle issue and writeback to x9: set wins, data stored
        iss_valid = 1; iss_rd = 9; we = 1; wa = 9; wd = 32'hA5; set_ra(9, 0);
        cycle("t5_both");
        idle_inputs();
        cycle("t5_after");
        chk("t5_busy0", {31'b0, rd_busy[0]}, 32'd1);
        chk("t5_rd0", rd[XLEN-1:0], 32'hA5);

        // randomized traffic on a small register window to force collisions
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom); wa = AW'($urandom_range(0, 7)); wd = $urandom;
            iss_valid = 1'($urandom); iss_rd = AW'($urandom_range(0, 7));
            set_ra($urandom_range(0, 7), $urandom_range(0, 7));
            cycle("rand");
        end
        idle_inputs();

        // reset mid-run restarts the sweep
        we = 1; wa = 3; wd = 32'hFF;
        cycle("t6_w3");
        idle_inputs(); iss_valid = 1; iss_rd = 4;
        cycle("t6_i4");
        idle_inputs(); set_ra(3, 4);
        cycle("t6_pre");
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        wait_init("t6");
        set_ra(3, 4);
        cycle("t6_post");
        chk("t6_x3", rd[XLEN-1:0], 32'h0);
        chk("t6_x4busy", {31'b0, rd_busy[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
